// File: rtl/nr_iter_ctrl.sv
// Broyden/Newton-Raphson iteration sequencer: feeds x/invJ to the iteration stage,
// captures its results on a qualified strobe edge and decides converge / iterate / stop.

module nr_elem_close #(
    parameter int TOL_ULP = 4
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        close,
    output logic        nonfinite
);
    localparam logic [23:0] TOL = 24'(TOL_ULP);

    logic [23:0] diff;

    always_comb begin
        diff = (a[22:0] >= b[22:0]) ? ({1'b0, a[22:0]} - {1'b0, b[22:0]})
                                    : ({1'b0, b[22:0]} - {1'b0, a[22:0]});
        // +0/-0 compare equal; differing exponents are never close
        close = (a == b)
             || ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
             || ((a[31] == b[31]) && (a[30:23] == b[30:23]) && (diff <= TOL));
        nonfinite = (a[30:23] == 8'hFF);
    end
endmodule

module nr_iter_ctrl #(
    parameter int MAX_ITER = 64,
    parameter int TOL_ULP  = 4,
    parameter int MIN_WAIT = 16,
    parameter int TIMEOUT  = 2047
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [95:0]  init_x,
    input  logic [383:0] init_invJ,
    output logic [95:0]  cur_x,
    output logic [383:0] cur_invJ,
    input  logic [95:0]  new_x,
    input  logic [383:0] new_invJ,
    input  logic         iter_stb,
    output logic         busy,
    output logic         done,
    output logic [1:0]   status,
    output logic [7:0]   iter_count
);
    localparam int          NUM_LANES = 3;
    localparam logic [10:0] MIN_W     = 11'(MIN_WAIT);
    localparam logic [10:0] TMO       = 11'(TIMEOUT);
    localparam logic [7:0]  MAX_I     = 8'(MAX_ITER);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t         state, state_nxt;
    logic           stb_q;
    logic [10:0]    wait_cnt;
    logic [95:0]    cand_x;
    logic [383:0]   cand_invJ;
    logic [NUM_LANES-1:0] elem_close, elem_nf;
    logic           accept, tmo, all_close, any_nf, last_iter;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        nr_elem_close #(.TOL_ULP(TOL_ULP)) u_close (
            .a         (cand_x[32*i +: 32]),
            .b         (cur_x[32*i +: 32]),
            .close     (elem_close[i]),
            .nonfinite (elem_nf[i])
        );
    end

    assign accept    = iter_stb && !stb_q && (wait_cnt >= MIN_W);
    assign tmo       = (wait_cnt == TMO);
    assign all_close = &elem_close;
    assign any_nf    = |elem_nf;
    assign last_iter = ((iter_count + 8'd1) == MAX_I);
    assign busy      = (state == S_WAIT) || (state == S_CHECK);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_WAIT;
            // capture wins over timeout when both land on the same cycle
            S_WAIT: begin
                if (accept)   state_nxt = S_CHECK;
                else if (tmo) state_nxt = S_DONE;
            end
            S_CHECK: state_nxt = (any_nf || all_close || last_iter) ? S_DONE : S_WAIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stb_q      <= 1'b0;
            wait_cnt   <= '0;
            cur_x      <= '0;
            cur_invJ   <= '0;
            cand_x     <= '0;
            cand_invJ  <= '0;
            status     <= 2'd0;
            iter_count <= '0;
        end else begin
            stb_q <= iter_stb;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cur_x      <= init_x;
                        cur_invJ   <= init_invJ;
                        iter_count <= '0;
                        wait_cnt   <= '0;
                        status     <= 2'd0;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 11'd1;
                    if (accept) begin
                        cand_x    <= new_x;
                        cand_invJ <= new_invJ;
                    end else if (tmo) begin
                        status <= 2'd2;
                    end
                end
                S_CHECK: begin
                    iter_count <= iter_count + 8'd1;
                    // a non-finite candidate leaves the last good vector in place
                    if (any_nf) begin
                        status <= 2'd3;
                    end else begin
                        cur_x    <= cand_x;
                        cur_invJ <= cand_invJ;
                        if (all_close)      status   <= 2'd0;
                        else if (last_iter) status   <= 2'd1;
                        else                wait_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nr_iter_ctrl.sv
// Self-checking bench for nr_iter_ctrl: vector table of single-iteration solves plus
// hand sequences for reset, max-iteration, timeout, strobe filtering and restart.

module tb_nr_iter_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [95:0]  init_x;
    logic [383:0] init_invJ;
    logic [95:0]  cur_x;
    logic [383:0] cur_invJ;
    logic [95:0]  new_x;
    logic [383:0] new_invJ;
    logic         iter_stb;
    logic         busy, done;
    logic [1:0]   status;
    logic [7:0]   iter_count;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [95:0] ix;
        logic [95:0] nx;
        logic [1:0]  st;
        logic [7:0]  cnt;
        logic [95:0] ex_x;
        logic        ex_inv_new;
    } vec_t;

    typedef struct {
        logic [1:0]   st;
        logic [7:0]   cnt;
        logic [95:0]  x;
        logic [383:0] inv;
    } exp_t;

    vec_t         vecs[7];
    exp_t         sb[$];
    logic [383:0] ij, nj;

    nr_iter_ctrl #(.MAX_ITER(8), .TOL_ULP(4), .MIN_WAIT(16), .TIMEOUT(2047)) dut (
        .clk(clk), .rst(rst), .start(start), .init_x(init_x), .init_invJ(init_invJ),
        .cur_x(cur_x), .cur_invJ(cur_invJ), .new_x(new_x), .new_invJ(new_invJ),
        .iter_stb(iter_stb), .busy(busy), .done(done), .status(status),
        .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_solve();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // strobe sampled with wait_cnt == d; returns right after the CHECK cycle
    task automatic respond(input int d, input logic [95:0] nx);
        tick(d);
        new_x    = nx;
        iter_stb = 1'b1;
        tick(1);
        iter_stb = 1'b0;
        tick(1);
    endtask

    task automatic push_exp(input logic [1:0] st, input logic [7:0] cnt,
                            input logic [95:0] x, input logic [383:0] inv);
        exp_t e;
        e.st = st; e.cnt = cnt; e.x = x; e.inv = inv;
        sb.push_back(e);
    endtask

    task automatic finish_check(input string tag, input int limit);
        exp_t e;
        int   n = 0;
        while (!done && n < limit) begin
            tick(1);
            n++;
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_sb"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_status"}, status, e.st);
            check({tag, "_iter"}, iter_count, e.cnt);
            check({tag, "_x"}, cur_x, e.x);
            check({tag, "_invJ"}, cur_invJ, e.inv);
            check({tag, "_busy"}, busy, 1'b0);
        end
    endtask

    initial begin
        int n;
        for (int k = 0; k < 12; k++) begin
            ij[32*k +: 32] = 32'h3E000000 + 32'(k);
            nj[32*k +: 32] = 32'h3D000000 + 32'(k);
        end
        vecs[0] = '{{3{32'h3F800000}}, {3{32'h3F800003}}, 2'd0, 8'd1, {3{32'h3F800003}}, 1'b1};
        vecs[1] = '{{3{32'h3F800000}}, {32'h3F800000, 32'h3F800000, 32'h7FC00000}, 2'd3, 8'd1,
                    {3{32'h3F800000}}, 1'b0};
        vecs[2] = '{{32'h3F800000, 32'h3F800000, 32'h00000000},
                    {32'h3F800000, 32'h3F800000, 32'h80000000}, 2'd0, 8'd1,
                    {32'h3F800000, 32'h3F800000, 32'h80000000}, 1'b1};
        vecs[3] = '{{3{32'h3F800004}}, {3{32'h3F800000}}, 2'd0, 8'd1, {3{32'h3F800000}}, 1'b1};
        vecs[4] = '{{3{32'h40A00000}}, {32'h7F800000, 32'h40A00000, 32'h40A00000}, 2'd3, 8'd1,
                    {3{32'h40A00000}}, 1'b0};
        vecs[5] = '{{32'hC0400001, 32'hBF800001, 32'h40400000},
                    {32'hC0400001, 32'hBF800000, 32'h40400002}, 2'd0, 8'd1,
                    {32'hC0400001, 32'hBF800000, 32'h40400002}, 1'b1};
        vecs[6] = '{{3{32'h12345678}}, {3{32'h12345678}}, 2'd0, 8'd1, {3{32'h12345678}}, 1'b1};

        rst = 1'b0; start = 1'b0; iter_stb = 1'b0;
        init_x = '0; init_invJ = ij; new_x = '0; new_invJ = nj;
        tick(2);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_status", status, 2'd0);
        check("rst_iter", iter_count, 8'd0);
        check("rst_x", cur_x, 96'd0);
        check("rst_invJ", cur_invJ, 384'd0);
        rst = 1'b1;
        tick(2);

        for (int v = 0; v < 7; v++) begin
            init_x = vecs[v].ix;
            start_solve();
            check($sformatf("v%0d_busy", v), busy, 1'b1);
            check($sformatf("v%0d_x0", v), cur_x, vecs[v].ix);
            push_exp(vecs[v].st, vecs[v].cnt, vecs[v].ex_x, vecs[v].ex_inv_new ? nj : ij);
            respond(20, vecs[v].nx);
            check($sformatf("v%0d_lat", v), done, 1'b1);
            finish_check($sformatf("v%0d", v), 4);
        end

        // iterate: ignored restart, tol+1 miss, sign miss, then exact match
        init_x = {3{32'h3F800000}};
        start_solve();
        tick(3);
        init_x = {3{32'h40000000}};
        start_solve();
        check("ign_start_x", cur_x, {3{32'h3F800000}});
        respond(16, {3{32'h3F800005}});
        check("it1_iter", iter_count, 8'd1);
        check("it1_done", done, 1'b0);
        check("it1_x", cur_x, {3{32'h3F800005}});
        respond(20, {3{32'hBF800005}});
        check("it2_iter", iter_count, 8'd2);
        check("it2_done", done, 1'b0);
        push_exp(2'd0, 8'd3, {3{32'hBF800005}}, nj);
        respond(20, {3{32'hBF800005}});
        finish_check("it3", 4);

        // max iterations with alternating exponents
        init_x = {3{32'h3F800000}};
        start_solve();
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) push_exp(2'd1, 8'd8, {3{32'h3F800000}}, nj);
            respond(20, (k % 2 == 1) ? {3{32'h40000000}} : {3{32'h3F800000}});
            if (k < 8) begin
                check($sformatf("max_it%0d_iter", k), iter_count, 8'(k));
                check($sformatf("max_it%0d_busy", k), busy, 1'b1);
            end
        end
        finish_check("maxit", 4);

        // strobe filtering: early edge held high is never re-accepted
        init_x = {3{32'h3F800000}};
        start_solve();
        tick(5);
        new_x = {3{32'h3F800001}};
        iter_stb = 1'b1;
        tick(35);
        check("filt_iter", iter_count, 8'd0);
        check("filt_busy", busy, 1'b1);
        iter_stb = 1'b0;
        tick(60);
        check("filt_hold_done", done, 1'b0);
        iter_stb = 1'b1;
        tick(1);
        iter_stb = 1'b0;
        check("filt_check_done", done, 1'b0);
        push_exp(2'd0, 8'd1, {3{32'h3F800001}}, nj);
        tick(1);
        check("filt_lat", done, 1'b1);
        finish_check("filt", 4);

        // timeout
        init_x = {3{32'h3F800000}};
        start_solve();
        n = 0;
        while (!done && n < 2100) begin
            tick(1);
            n++;
        end
        check("tmo_cycles", 32'(n + 1), 32'd2049);
        check("tmo_status", status, 2'd2);
        check("tmo_iter", iter_count, 8'd0);

        // edge on the timeout cycle is captured
        start_solve();
        push_exp(2'd0, 8'd1, {3{32'h3F800002}}, nj);
        respond(2047, {3{32'h3F800002}});
        finish_check("tmo_edge", 2);

        // asynchronous reset mid-solve
        init_x = {3{32'h3F800000}};
        start_solve();
        tick(300);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_iter", iter_count, 8'd0);
        check("mid_rst_x", cur_x, 96'd0);
        rst = 1'b1;
        tick(5);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_done", done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
